// File: rtl/cr_im_bank_producer.sv
// Ping-pong capture producer: streams captured entries into two memory banks and hands full banks to a reader.
// Optional feature: define CR_IM_DROP_CNT_EN to build the saturating dropped-capture counter.
module cr_im_bank_producer #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_enable,
    input  logic                     cfg_flush,
    input  logic                     capture_vld,
    input  logic [DATA_W-1:0]        capture_data,
    input  logic [1:0]               im_consumed,
    output logic [1:0]               im_available,
    output logic                     im_wr_en,
    output logic [$clog2(DEPTH):0]   im_wr_addr,
    output logic [DATA_W-1:0]        im_wr_data,
    output logic [31:0]              im_drop_cnt
);

    localparam int LW = $clog2(DEPTH);
    localparam logic [LW-1:0] IDX_LAST = LW'(DEPTH - 1);
    localparam logic [LW-1:0] IDX_ZERO = {LW{1'b0}};

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_FILLING = 2'd1,
        B_AVAIL   = 2'd2
    } bank_state_t;

    bank_state_t        lo_state_r;
    bank_state_t        hi_state_r;
    bank_state_t        lo_state_s;
    bank_state_t        hi_state_s;
    logic [LW-1:0]      idx_r;
    logic [LW-1:0]      idx_s;
    logic               lo_fill_s;
    logic               hi_fill_s;
    logic               filling_s;
    logic               accept_s;
    logic               close_s;
    logic               lo_rel_s;
    logic               hi_rel_s;
    logic               wr_en_r;
    logic [LW:0]        wr_addr_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [1:0]         avail_r;

    // Bank state and write index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_state_r <= B_FILLING;
            hi_state_r <= B_FREE;
            idx_r      <= IDX_ZERO;
        end else begin
            lo_state_r <= lo_state_s;
            hi_state_r <= hi_state_s;
            idx_r      <= idx_s;
        end
    end

    // Capture acceptance, bank closing and next bank states
    always_comb begin
        lo_fill_s  = (lo_state_r == B_FILLING);
        hi_fill_s  = (hi_state_r == B_FILLING);
        filling_s  = lo_fill_s | hi_fill_s;
        accept_s   = capture_vld & cfg_enable & filling_s;
        lo_rel_s   = im_consumed[0] & (lo_state_r == B_AVAIL);
        hi_rel_s   = im_consumed[1] & (hi_state_r == B_AVAIL);
        // A flush closes the bank only when it actually holds entries.
        close_s    = (accept_s & (idx_r == IDX_LAST)) |
                     (cfg_flush & filling_s & (idx_r != IDX_ZERO));
        lo_state_s = lo_rel_s ? B_FREE : lo_state_r;
        hi_state_s = hi_rel_s ? B_FREE : hi_state_r;

        if (close_s) begin
            idx_s = IDX_ZERO;
        end else if (accept_s) begin
            idx_s = idx_r + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            idx_s = idx_r;
        end

        if (close_s) begin
            // The partner is judged on its state before this cycle's release.
            if (lo_fill_s) begin
                lo_state_s = B_AVAIL;
                if (hi_state_r == B_FREE) begin
                    hi_state_s = B_FILLING;
                end else begin
                    hi_state_s = hi_rel_s ? B_FREE : hi_state_r;
                end
            end else begin
                hi_state_s = B_AVAIL;
                if (lo_state_r == B_FREE) begin
                    lo_state_s = B_FILLING;
                end else begin
                    lo_state_s = lo_rel_s ? B_FREE : lo_state_r;
                end
            end
        end else if (!filling_s) begin
            if ((lo_state_r == B_FREE) || lo_rel_s) begin
                lo_state_s = B_FILLING;
            end else if ((hi_state_r == B_FREE) || hi_rel_s) begin
                hi_state_s = B_FILLING;
            end else begin
                lo_state_s = lo_state_r;
                hi_state_s = hi_state_r;
            end
        end else begin
            lo_state_s = lo_rel_s ? B_FREE : lo_state_r;
            hi_state_s = hi_rel_s ? B_FREE : hi_state_r;
        end
    end

    // Registered memory write port and availability flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {(LW+1){1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            avail_r   <= 2'b00;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= {hi_fill_s, idx_r};
                wr_data_r <= capture_data;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
            avail_r <= {(hi_state_r == B_AVAIL), (lo_state_r == B_AVAIL)};
        end
    end

    assign im_wr_en     = wr_en_r;
    assign im_wr_addr   = wr_addr_r;
    assign im_wr_data   = wr_data_r;
    assign im_available = avail_r;

`ifdef CR_IM_DROP_CNT_EN
    logic        drop_s;
    logic [31:0] drop_cnt_r;

    assign drop_s = capture_vld & cfg_enable & ~filling_s;

    // Saturating count of captures offered while no bank was filling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 32'd0;
        end else if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
            drop_cnt_r <= drop_cnt_r + 32'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign im_drop_cnt = drop_cnt_r;
`else
    assign im_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cr_im_bank_producer.sv
// Scoreboard bench for cr_im_bank_producer with DEPTH=4.
module tb_cr_im_bank_producer;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic        cfg_flush;
    logic        capture_vld;
    logic [63:0] capture_data;
    logic [1:0]  im_consumed;
    logic [1:0]  im_available;
    logic        im_wr_en;
    logic [2:0]  im_wr_addr;
    logic [63:0] im_wr_data;
    logic [31:0] im_drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [66:0] exp_q[$];

    cr_im_bank_producer #(.DEPTH(4), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
        .capture_vld(capture_vld), .capture_data(capture_data), .im_consumed(im_consumed),
        .im_available(im_available), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .im_drop_cnt(im_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [66:0] e;
        if (rst_n && im_wr_en) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", im_wr_addr, im_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({im_wr_addr, im_wr_data} !== e) begin
                    bad = bad + 1;
                    $display("FAIL wr_match: got addr=%0d data=%h, required addr=%0d data=%h",
                             im_wr_addr, im_wr_data, e[66:64], e[63:0]);
                end
            end
        end
    end

    function automatic logic [31:0] exp_drop(input logic [31:0] n);
`ifdef CR_IM_DROP_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic drive(input logic vld, input logic en, input logic flush, input logic [1:0] cons,
                         input logic [63:0] d, input logic exp_wr, input logic [2:0] exp_addr);
        @(posedge clk);
        #1;
        capture_vld  = vld;
        cfg_enable   = en;
        cfg_flush    = flush;
        im_consumed  = cons;
        capture_data = d;
        if (exp_wr) exp_q.push_back({exp_addr, d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 3'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        capture_vld = 1'b0; cfg_flush = 1'b0; im_consumed = 2'b00; cfg_enable = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        capture_vld = 1'b0; cfg_flush = 1'b0; im_consumed = 2'b00; cfg_enable = 1'b1;
        capture_data = 64'd0;
        repeat (2) @(negedge clk);
        total = total + 1;
        if ({im_wr_en, im_wr_addr, im_wr_data, im_available, im_drop_cnt} !== 102'd0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h avail=%b drop=%0d, required all 0",
                     im_wr_en, im_wr_addr, im_wr_data, im_available, im_drop_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_both();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hA000 + 64'(i), 1'b1, 3'(i));
        idle(1);
        total = total + 1;
        if (im_available !== 2'b00) begin
            bad = bad + 1;
            $display("FAIL avail_early: got %b, required 00", im_available);
        end
        idle(1);
        total = total + 1;
        if (im_available !== 2'b01) begin
            bad = bad + 1;
            $display("FAIL avail_lo: got %b, required 01", im_available);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hB000 + 64'(i), 1'b1, 3'(4 + i));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hDEAD, 1'b0, 3'd0);
        idle(2);
        total = total + 1;
        if (im_available !== 2'b11) begin
            bad = bad + 1;
            $display("FAIL avail_both: got %b, required 11", im_available);
        end
        total = total + 1;
        if (im_drop_cnt !== exp_drop(32'd3)) begin
            bad = bad + 1;
            $display("FAIL drop_three: got %0d, required %0d", im_drop_cnt, exp_drop(32'd3));
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL fill_missing: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_release();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 64'hC0DE, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hC001, 1'b1, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 64'hC002, 1'b0, 3'd0);
        idle(2);
        total = total + 1;
        if (im_available !== 2'b10) begin
            bad = bad + 1;
            $display("FAIL release_avail: got %b, required 10", im_available);
        end
        total = total + 1;
        if (im_drop_cnt !== exp_drop(32'd4)) begin
            bad = bad + 1;
            $display("FAIL release_drop: got %0d, required %0d", im_drop_cnt, exp_drop(32'd4));
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL release_missing: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hF000, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hF001, 1'b1, 3'd1);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 1'b0, 3'd0);
        idle(1);
        total = total + 1;
        if (im_available !== 2'b01) begin
            bad = bad + 1;
            $display("FAIL flush_avail: got %b, required 01", im_available);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hF002, 1'b1, 3'd4);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 64'hF003, 1'b1, 3'd5);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'hF004, 1'b0, 3'd0);
        idle(2);
        total = total + 1;
        if (im_available !== 2'b11) begin
            bad = bad + 1;
            $display("FAIL flush_capture_avail: got %b, required 11", im_available);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL flush_missing: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_consume_ignore();
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h1000 + 64'(i), 1'b1, 3'(i));
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h2000, 1'b1, 3'd4);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 64'h2001, 1'b1, 3'd5);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h2002, 1'b1, 3'd6);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h2003, 1'b1, 3'd7);
        idle(2);
        total = total + 1;
        if (im_available !== 2'b11) begin
            bad = bad + 1;
            $display("FAIL ignore_avail: got %b, required 11", im_available);
        end
        drive(1'b0, 1'b1, 1'b0, 2'b11, 64'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h3000 + 64'(i), 1'b1, 3'(i));
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h3004, 1'b1, 3'd4);
        idle(2);
        total = total + 1;
        if (im_available !== 2'b01) begin
            bad = bad + 1;
            $display("FAIL dual_release_avail: got %b, required 01", im_available);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL ignore_missing: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h4000, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h4001, 1'b1, 3'd1);
        idle(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total = total + 1;
        if ({im_wr_en, im_wr_addr, im_wr_data, im_available, im_drop_cnt} !== 102'd0) begin
            bad = bad + 1;
            $display("FAIL midreset_outputs: got wr_en=%b addr=%0d data=%h avail=%b drop=%0d, required all 0",
                     im_wr_en, im_wr_addr, im_wr_data, im_available, im_drop_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, 64'h5000 + 64'(i), 1'b1, 3'(i));
        idle(2);
        total = total + 1;
        if (im_available !== 2'b01) begin
            bad = bad + 1;
            $display("FAIL midreset_avail: got %b, required 01", im_available);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL midreset_missing: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_both();
        test_release();
        test_flush();
        test_consume_ignore();
        test_mid_reset();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cr_im_bank_producer.md
CR_IM_BANK_PRODUCER -- requirements
Module: cr_im_bank_producer

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning entries per bank (power of two, at least 4).
REQ-002 SHALL have parameter DATA_W, default 64, meaning captured entry width.
REQ-003 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port cfg_enable  input  1  meaning capture enable (level).
REQ-006 SHALL have port cfg_flush  input  1  meaning single-cycle pulse that closes a partially filled bank.
REQ-007 SHALL have port capture_vld  input  1  meaning capture_data is valid this cycle.
REQ-008 SHALL have port capture_data  input  DATA_W  meaning entry to store.
REQ-009 SHALL have port im_consumed  input  im_consumed_t (bank_lo, bank_hi; 2 bits)  meaning single-cycle release pulses from the reader.
REQ-010 SHALL have port im_available  output  im_available_t (bank_lo, bank_hi; 2 bits)  meaning bank full and readable (level).
REQ-011 SHALL have port im_wr_en  output  1  meaning memory write strobe.
REQ-012 SHALL have port im_wr_addr  output  log2(DEPTH)+1  meaning {bank, index}, where bank_lo=0 and bank_hi=1.
REQ-013 SHALL have port im_wr_data  output  DATA_W  meaning memory write data.
REQ-014 SHALL have port im_drop_cnt  output  32  meaning the count of dropped captures.

Function
REQ-015 Each bank SHALL be in one of three states: FREE, FILLING or AVAIL.
REQ-016 Out of reset, bank_lo SHALL be FILLING and bank_hi SHALL be FREE.
REQ-017 The write index SHALL be 0 out of reset.
REQ-018 A capture SHALL be accepted when capture_vld=1, cfg_enable=1 and a bank is FILLING.
REQ-019 An accepted capture SHALL produce im_wr_en=1 exactly 1 cycle later, with the registered address and data.
REQ-020 The write index SHALL increment on each accepted capture and SHALL wrap to 0 after DEPTH-1.
REQ-021 When the index wraps, the FILLING bank SHALL go to AVAIL, and im_available for that bank SHALL be 1 on the cycle after the last write strobe is issued.
REQ-022 On the wrap cycle, if the other bank is FREE (state before this cycle's im_consumed is applied), it SHALL become FILLING; otherwise no bank SHALL be FILLING (WAIT).
REQ-023 In WAIT, the first bank released by im_consumed SHALL become FILLING on the cycle after the release pulse.
REQ-024 A capture offered in WAIT or in that release cycle SHALL be dropped.
REQ-025 im_consumed for a bank in AVAIL SHALL set that bank to FREE on the next cycle.
REQ-026 im_consumed for a bank not in AVAIL SHALL be ignored.
REQ-027 cfg_flush with index>0 SHALL close the FILLING bank exactly as a wrap does (REQ-021, REQ-022) and SHALL reset the index to 0.
REQ-028 cfg_flush with index=0, or in WAIT, SHALL be ignored.
REQ-029 A capture accepted in the same cycle as cfg_flush SHALL be written into the closing bank and counted before it closes.
REQ-030 capture_vld=1 with cfg_enable=0 SHALL be ignored and SHALL NOT count as a drop.
REQ-031 im_consumed pulses for both banks in the same cycle SHALL each be honoured independently.

Reset
REQ-032 Asserting rst_n low SHALL immediately clear im_wr_en, im_wr_addr, im_wr_data, im_available and im_drop_cnt to 0.
REQ-033 Asserting rst_n low SHALL restore the bank states of REQ-016.
REQ-034 Reset asserted mid-fill SHALL discard the partial bank, with no AVAIL indication for it.
REQ-035 Reset deassertion SHALL be synchronised by the existing reset tree; no internal synchroniser is required.

Configuration
REQ-036 With CR_IM_DROP_CNT_EN defined, im_drop_cnt SHALL increment by 1 per dropped capture and SHALL saturate at 0xFFFFFFFF.
REQ-037 With CR_IM_DROP_CNT_EN undefined, im_drop_cnt SHALL be tied to 0 and no counter flops SHALL exist.
REQ-038 All other behaviour SHALL be identical with or without CR_IM_DROP_CNT_EN.

Verification
REQ-039 DEPTH=4, enable, 4 back-to-back captures D0..D3 -> SHALL see writes to addr 0..3, then im_available=2'b01 (bank_lo) and further writes going to addr 4 onward.
REQ-040 Fill both banks (8 captures), then 3 more captures -> SHALL see im_available=2'b11, no write strobes, and drop_cnt=3 (0 without the macro).
REQ-041 From that state, im_consumed.bank_lo pulse with capture_vld held high -> SHALL see bank_lo released, the capture in the release cycle dropped, and the next capture written to addr 0.
REQ-042 2 captures then cfg_flush -> SHALL see bank_lo AVAIL with 2 entries and the next capture written to addr 4; a second cfg_flush with index 0 SHALL have no effect.
REQ-043 im_consumed.bank_hi while bank_hi is FILLING -> SHALL be ignored, with filling continuing uninterrupted.
REQ-044 rst_n pulsed low after 2 captures -> SHALL see all outputs 0, and the next capture written to addr 0 with bank_lo FILLING.
